vga_sync_gen: RTL and testbench

- Upstream timing stage for all overlay renderers: title text, credit line, sprites, score.
- Divides the system clock into a pixel-rate clock enable.
- Runs horizontal/vertical counters for 640x480@60 and drives registered pixel_x, pixel_y, video_on, hsync, vsync.
- Every downstream renderer consumes pixel_x/pixel_y/video_on combinationally; the pixel mux drives hsync/vsync to the VGA connector.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/pixel_tick_gen.sv | 37 +++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 tb/tb_vga_sync_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, coordinate type and decode helper,
// used by the sync generator and every overlay renderer.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Both sync pulses are active-low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int SCREEN_W = H_DISPLAY;
    localparam int SCREEN_H = V_DISPLAY;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test lo <= v < hi, unsigned.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides clk by CLK_DIV into a registered one-clk pixel enable; the first
// enable is high in clk cycle CLK_DIV after reset release.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int                CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p_tick_q, p_tick_d;

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        // Registered from the next count so the pulse lands in the last phase slot.
        p_tick_d = (cnt_d == CNT_LAST);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            p_tick_q <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, horizontal/vertical counters and
// registered video_on/hsync/vsync/frame_start aligned to pixel_x/pixel_y.
module vga_sync_gen
    import vga_timing_pkg::COORD_W, vga_timing_pkg::coord_t,
           vga_timing_pkg::SYNC_ACTIVE, vga_timing_pkg::in_window;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int     H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   tick;
    coord_t x_q, x_d, y_q, y_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // Decoding the next-state counters keeps these flops in step with pixel_x/pixel_y.
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d    = in_window(x_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = in_window(y_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full 640x480 instance for line timing and a
// tiny-parameter instance for frame timing, sharing clock and reset.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset;

    logic        d_p_tick, d_video_on, d_hsync, d_vsync, d_frame_start;
    logic [10:0] d_x, d_y;
    logic        s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
    logic [10:0] s_x, s_y;

    int unsigned edge_cnt;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_d (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (d_p_tick),
        .pixel_x     (d_x),
        .pixel_y     (d_y),
        .video_on    (d_video_on),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .frame_start (d_frame_start)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_dut_s (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (s_p_tick),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .video_on    (s_video_on),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .frame_start (s_frame_start)
    );

    // Edges since reset release, 1-based after the first edge.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to 1 time unit after edge n (counted from reset release).
    task automatic goto_edge(input int unsigned n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, vl, hl, mx, my, hsl, von;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_p_tick",  d_p_tick, 0);
        check("rst_d_x",       d_x, 0);
        check("rst_d_y",       d_y, 0);
        check("rst_d_video",   d_video_on, 0);
        check("rst_d_hsync",   d_hsync, 1);
        check("rst_d_vsync",   d_vsync, 1);
        check("rst_d_fstart",  d_frame_start, 0);
        check("rst_s_p_tick",  s_p_tick, 0);
        check("rst_s_hsync",   s_hsync, 1);
        @(negedge clk);
        reset = 1'b0;

        // Reset release: tick phase and first-edge decode
        goto_edge(1);
        check("e1_d_p_tick",   d_p_tick, 0);
        check("e1_d_video",    d_video_on, 1);
        check("e1_d_hsync",    d_hsync, 1);
        check("e1_d_vsync",    d_vsync, 1);
        check("e1_d_x",        d_x, 0);
        check("e1_d_fstart",   d_frame_start, 0);
        check("e1_s_p_tick",   s_p_tick, 1);
        goto_edge(2);
        check("e2_d_p_tick",   d_p_tick, 0);
        check("e2_s_x",        s_x, 1);
        check("e2_s_p_tick",   s_p_tick, 0);
        goto_edge(3);
        check("e3_d_p_tick",   d_p_tick, 1);
        check("e3_d_x",        d_x, 0);
        goto_edge(4);
        check("e4_d_p_tick",   d_p_tick, 0);
        check("e4_d_x",        d_x, 1);
        goto_edge(7);
        check("e7_d_p_tick",   d_p_tick, 1);

        // Small instance: horizontal windows (x 10..11 sync, visible 0..7)
        goto_edge(15);
        check("s_x7_video",    s_video_on, 1);
        goto_edge(16);
        check("s_x8",          s_x, 8);
        check("s_x8_video",    s_video_on, 0);
        goto_edge(19);
        check("s_x9_hsync",    s_hsync, 1);
        goto_edge(20);
        check("s_x10",         s_x, 10);
        check("s_x10_hsync",   s_hsync, 0);
        goto_edge(24);
        check("s_x12_hsync",   s_hsync, 1);
        goto_edge(28);
        check("s_wrap_x",      s_x, 0);
        check("s_wrap_y",      s_y, 1);
        check("s_wrap_video",  s_video_on, 1);

        // Small instance: vertical windows (y 5 sync, visible 0..3)
        goto_edge(112);
        check("s_y4",          s_y, 4);
        check("s_y4_video",    s_video_on, 0);
        goto_edge(139);
        check("s_y4x13_vsync", s_vsync, 1);
        goto_edge(140);
        check("s_y5",          s_y, 5);
        check("s_y5_vsync",    s_vsync, 0);
        goto_edge(168);
        check("s_y6_vsync",    s_vsync, 1);

        // Small instance: simultaneous wrap at (13,6)
        goto_edge(195);
        check("s_last_x",      s_x, 13);
        check("s_last_y",      s_y, 6);
        check("s_last_tick",   s_p_tick, 1);
        check("s_last_fstart", s_frame_start, 0);
        goto_edge(196);
        check("s_fw_x",        s_x, 0);
        check("s_fw_y",        s_y, 0);
        check("s_fw_fstart",   s_frame_start, 1);
        check("s_fw_video",    s_video_on, 1);
        goto_edge(197);
        check("s_fw1_fstart",  s_frame_start, 0);

        // One full small frame: 98 ticks, sync counts, next frame_start at 392
        fs = 0; vl = 0; hl = 0; mx = 0; my = 0;
        for (int e = 197; e <= 392; e++) begin
            goto_edge(e);
            if (s_frame_start) fs++;
            if (s_p_tick && !s_vsync) vl++;
            if (s_p_tick && !s_hsync) hl++;
            if (int'(s_x) > mx) mx = int'(s_x);
            if (int'(s_y) > my) my = int'(s_y);
        end
        check("s_frame_fstart_cnt", fs, 1);
        check("s_frame_vsync_ticks", vl, 14);
        check("s_frame_hsync_ticks", hl, 14);
        check("s_frame_max_x", mx, 13);
        check("s_frame_max_y", my, 6);

        // Full-size instance: horizontal boundaries
        goto_edge(2556);
        check("d_x639",        d_x, 639);
        check("d_x639_video",  d_video_on, 1);
        goto_edge(2560);
        check("d_x640_video",  d_video_on, 0);
        goto_edge(2620);
        check("d_x655",        d_x, 655);
        check("d_x655_hsync",  d_hsync, 1);
        goto_edge(2624);
        check("d_x656_hsync",  d_hsync, 0);
        goto_edge(3004);
        check("d_x751",        d_x, 751);
        check("d_x751_hsync",  d_hsync, 0);
        goto_edge(3008);
        check("d_x752_hsync",  d_hsync, 1);
        goto_edge(3199);
        check("d_x799",        d_x, 799);
        check("d_x799_y",      d_y, 0);
        check("d_x799_tick",   d_p_tick, 1);
        goto_edge(3200);
        check("d_lw_x",        d_x, 0);
        check("d_lw_y",        d_y, 1);
        check("d_lw_video",    d_video_on, 1);
        check("d_lw_hsync",    d_hsync, 1);

        // One full line: 96 ticks of hsync, 640 visible ticks, period 3200 clks
        hsl = 0; von = 0;
        for (int e = 3200; e <= 6399; e++) begin
            goto_edge(e);
            if (d_p_tick && !d_hsync) hsl++;
            if (d_p_tick && d_video_on) von++;
        end
        check("d_line_hsync_ticks", hsl, 96);
        check("d_line_video_ticks", von, 640);
        goto_edge(6400);
        check("d_lw2_x",       d_x, 0);
        check("d_lw2_y",       d_y, 2);

        // Async reset in the middle of an hsync pulse, between clock edges
        goto_edge(9200);
        check("d_pre_rst_x",     d_x, 700);
        check("d_pre_rst_hsync", d_hsync, 0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_d_x",      d_x, 0);
        check("arst_d_y",      d_y, 0);
        check("arst_d_hsync",  d_hsync, 1);
        check("arst_d_video",  d_video_on, 0);
        check("arst_d_p_tick", d_p_tick, 0);
        check("arst_s_x",      s_x, 0);
        check("arst_s_y",      s_y, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        goto_edge(1);
        check("re1_d_hsync",   d_hsync, 1);
        check("re1_d_video",   d_video_on, 1);
        check("re1_d_p_tick",  d_p_tick, 0);
        goto_edge(2);
        check("re2_s_x",       s_x, 1);
        check("re2_s_y",       s_y, 0);
        goto_edge(3);
        check("re3_d_p_tick",  d_p_tick, 1);
        check("re3_d_x",       d_x, 0);
        goto_edge(4);
        check("re4_d_x",       d_x, 1);
        check("re4_d_y",       d_y, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
